// File: rtl/addmop_seq_ctrl.sv
// addmop_seq_ctrl: time-multiplexed multi-operand reduction over a shared adder datapath
package lau_pkg;
  typedef enum logic {SLOW, FAST} speed_e;
endpackage

module addmop_dp #(
  parameter int width = 8,
  parameter int depth = 4,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
  input  logic [depth*width-1:0] i_op,
  output logic [width-1:0]       o_sum
);
  if (speed == lau_pkg::FAST) begin : g_csa
    logic [width-1:0] w_s, w_c, w_t;
    always_comb begin
      w_s = i_op[width-1:0];
      w_c = '0;
      w_t = '0;
      for (int i = 1; i < depth; i++) begin
        w_t = w_s ^ w_c ^ i_op[i*width +: width];
        w_c = ((w_s & w_c) | (w_s & i_op[i*width +: width]) | (w_c & i_op[i*width +: width])) << 1;
        w_s = w_t;
      end
      o_sum = w_s + w_c;
    end
  end else begin : g_rca
    always_comb begin
      o_sum = '0;
      for (int i = 0; i < depth; i++) o_sum = o_sum + i_op[i*width +: width];
    end
  end
endmodule

module addmop_seq_ctrl #(
  parameter int width = 8,
  parameter int depth = 4,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST,
  parameter int cnt_width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [cnt_width-1:0]       cmd_num_i,
  input  logic                       op_valid_i,
  output logic                       op_ready_o,
  input  logic [(depth-1)*width-1:0] op_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [width-1:0]           res_o,
  output logic                       busy_o
);
  localparam int L = depth - 1;
  localparam logic [cnt_width:0] LW = (cnt_width+1)'(L);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  state_e r_state, w_next;
  logic [width-1:0] r_acc, r_res, w_sum;
  logic [cnt_width-1:0] r_rem;
  logic [depth*width-1:0] w_ops;
  logic w_cmd_fire, w_op_fire, w_last;
  assign w_cmd_fire = cmd_valid_i && cmd_ready_o;
  assign w_op_fire = op_valid_i && op_ready_o;
  assign w_last = {1'b0, r_rem} <= LW;
  assign res_o = r_res;
  // lanes past the remaining count are zeroed so stale beat data never reaches the sum
  always_comb begin
    w_ops = '0;
    w_ops[width-1:0] = r_acc;
    for (int k = 0; k < L; k++)
      w_ops[(k+1)*width +: width] = ((cnt_width+1)'(k) < {1'b0, r_rem}) ? op_i[k*width +: width] : '0;
  end
  addmop_dp #(.width(width), .depth(depth), .speed(speed)) u_dp (.i_op(w_ops), .o_sum(w_sum));
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    cmd_ready_o = r_state == IDLE;
    op_ready_o = r_state == ACCUM;
    res_valid_o = r_state == DONE;
    busy_o = r_state != IDLE;
    w_next = r_state;
    if (w_cmd_fire) w_next = (cmd_num_i == '0) ? DONE : ACCUM;
    if (w_op_fire && w_last) w_next = DONE;
    if (res_valid_o && res_ready_i) w_next = IDLE;
  end
  // the result register is loaded only when entering DONE, so it holds across the next job
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_acc <= '0;
      r_rem <= '0;
      r_res <= '0;
    end else if (w_cmd_fire) begin
      r_acc <= '0;
      r_rem <= cmd_num_i;
      if (cmd_num_i == '0) r_res <= '0;
    end else if (w_op_fire) begin
      r_acc <= w_sum;
      r_rem <= w_last ? '0 : r_rem - LW[cnt_width-1:0];
      if (w_last) r_res <= w_sum;
    end
endmodule

// File: tb/tb_addmop_seq_ctrl.sv
// tb_addmop_seq_ctrl: directed and randomized jobs checked against a queue-sum reference model
module tb_addmop_seq_ctrl;
  localparam int W = 8, D = 4, L = D - 1, CW = 8;
  logic clk = 0, rst_n = 0, cmd_valid = 0, op_valid = 0, res_ready = 0;
  logic cmd_ready, op_ready, res_valid, busy;
  logic [CW-1:0] cmd_num = '0;
  logic [L*W-1:0] op = '0;
  logic [W-1:0] res;
  logic [W-1:0] vals[$];
  logic [W-1:0] junk = 8'd99;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  addmop_seq_ctrl #(.width(W), .depth(D), .cnt_width(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_num_i(cmd_num), .op_valid_i(op_valid), .op_ready_o(op_ready), .op_i(op),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_o(res), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int n, input int gap, input int hold, input bit chain, input int next_n);
    logic [W-1:0] exp_sum;
    int idx;
    int beats;
    exp_sum = '0;
    foreach (vals[i]) exp_sum = exp_sum + vals[i];
    idx = 0;
    beats = (n + L - 1) / L;
    cmd_valid = 1;
    cmd_num = CW'(n);
    chk("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = chain;
    cmd_num = CW'(next_n);
    chk("busy_after_cmd", busy, 1);
    chk("res_valid_after_cmd", res_valid, n == 0);
    chk("op_ready_after_cmd", op_ready, n != 0);
    for (int b = 0; b < beats; b++) begin
      repeat (gap) begin
        chk("op_ready_gap", op_ready, 1);
        chk("cmd_ready_accum", cmd_ready, 0);
        chk("busy_gap", busy, 1);
        tick();
      end
      for (int k = 0; k < L; k++) begin
        op[k*W +: W] = (idx < n) ? vals[idx] : junk;
        idx++;
      end
      op_valid = 1;
      chk("op_ready_beat", op_ready, 1);
      chk("res_valid_early", res_valid, 0);
      tick();
      op_valid = 0;
      op = (L*W)'($urandom);
    end
    chk("res_valid", res_valid, 1);
    chk("res_o", res, exp_sum);
    chk("op_ready_done", op_ready, 0);
    chk("cmd_ready_done", cmd_ready, 0);
    repeat (hold) begin
      tick();
      chk("res_valid_hold", res_valid, 1);
      chk("res_o_hold", res, exp_sum);
      chk("busy_hold", busy, 1);
      chk("cmd_ready_hold", cmd_ready, 0);
    end
    res_ready = 1;
    tick();
    res_ready = 0;
    chk("res_valid_after_rx", res_valid, 0);
    chk("cmd_ready_after_rx", cmd_ready, 1);
    chk("busy_after_rx", busy, 0);
    chk("res_o_kept", res, exp_sum);
  endtask

  initial begin
    int n;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_o", res, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    tick();
    vals = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    junk = 8'd99;
    run_job(5, 0, 0, 0, 0);
    vals = {};
    run_job(0, 0, 0, 0, 0);
    vals = '{8'd200, 8'd100, 8'd10};
    run_job(3, 0, 0, 0, 0);
    vals = {};
    repeat (255) vals.push_back(8'd1);
    run_job(255, 0, 0, 0, 0);
    vals = {};
    repeat (6) vals.push_back(W'($urandom));
    run_job(6, 3, 5, 0, 0);
    cmd_valid = 1;
    cmd_num = 8'd9;
    tick();
    cmd_valid = 0;
    op = (L*W)'($urandom);
    op_valid = 1;
    tick();
    op_valid = 0;
    chk("mid_busy", busy, 1);
    chk("mid_op_ready", op_ready, 1);
    rst_n = 0;
    #1;
    chk("abort_res_valid", res_valid, 0);
    chk("abort_op_ready", op_ready, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_res_o", res, 0);
    tick();
    rst_n = 1;
    tick();
    vals = '{8'd7, 8'd8};
    run_job(2, 0, 0, 0, 0);
    vals = {};
    repeat (3) vals.push_back(W'($urandom));
    run_job(3, 0, 0, 1, 4);
    vals = {};
    repeat (4) vals.push_back(W'($urandom));
    run_job(4, 0, 0, 0, 0);
    repeat (10) begin
      n = $urandom_range(0, 20);
      junk = W'($urandom);
      vals = {};
      repeat (n) vals.push_back(W'($urandom));
      run_job(n, $urandom_range(0, 2), $urandom_range(0, 3), 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
